// File: rtl/queue_pair_reader.sv
// Read-side controller for a 2-wide circular queue: pops a pair, captures it,
// and serialises lane 0 then lane 1 onto a scalar valid/ready port.
module queue_pair_reader #(
    parameter int WIDTH = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_flush,
    input  logic               i_q_empty,
    input  logic               i_q_push,
    input  logic [2*WIDTH-1:0] i_q_out,
    output logic               o_q_pop,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [WIDTH-1:0]   o_out_data,
    output logic               o_out_last,
    output logic [31:0]        o_pair_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_SEND0 = 2'd2,
        S_SEND1 = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_hold0;
    logic [WIDTH-1:0] r_hold1;
    logic [31:0]      r_pair_count;
    logic             w_pop_ok;
    logic             w_pair_done;
    logic             w_capture;

    // The queue ignores pop while push is high, so never request one then.
    assign w_pop_ok    = !i_q_empty && !i_q_push && !i_flush;
    assign w_pair_done = (r_state == S_SEND1) && i_out_ready && !i_flush;
    assign w_capture   = (r_state == S_WAIT) && !i_flush;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold0 <= '0;
            r_hold1 <= '0;
        end else if (w_capture) begin
            r_hold0 <= i_q_out[WIDTH-1:0];
            r_hold1 <= i_q_out[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pair_count <= '0;
        end else if (w_pair_done) begin
            r_pair_count <= r_pair_count + 32'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_q_pop     = 1'b0;
        o_out_valid = 1'b0;
        o_out_data  = '0;
        o_out_last  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pop_ok) begin
                    o_q_pop     = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_state_nxt = S_SEND0;
            end
            S_SEND0: begin
                o_out_valid = 1'b1;
                o_out_data  = r_hold0;
                if (i_out_ready) begin
                    w_state_nxt = S_SEND1;
                end
            end
            S_SEND1: begin
                o_out_valid = 1'b1;
                o_out_data  = r_hold1;
                o_out_last  = 1'b1;
                // Pop the next pair while lane 1 drains so only one bubble separates pairs.
                if (i_out_ready) begin
                    if (w_pop_ok) begin
                        o_q_pop     = 1'b1;
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (i_flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    assign o_pair_count = r_pair_count;

endmodule

// File: doc/queue_pair_reader.md
Name: queue_pair_reader

Overview:
- Read-side controller for the 2-wide circular queue.
- Issues pops when a pair is available, captures the pair returned on the queue's registered out[0]/out[1] one cycle later, and serialises the two entries onto a scalar valid/ready consumer port, lane 0 first.
- Sits between an instruction/rename queue and a single-issue downstream stage.
- Supports flush (mispredict/redirect) and tracks pairs consumed.

Parameters:
- WIDTH, 32, bit width of each queue entry and of out_data.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous discard of held/in-flight pair; FSM returns to IDLE.
- q_empty  input  1  queue empty flag (no pair available).
- q_push  input  1  queue push strobe this cycle; the queue ignores pop while push is high.
- q_out  input  WIDTH x2  queue pop data; valid in the cycle after an accepted pop.
- q_pop  output  1  pop request to queue; combinational from state and inputs.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
- out_data  output  WIDTH  current entry (lane 0 then lane 1).
- out_last  output  1  high when out_data is lane 1 of the pair.
- pair_count  output  32  number of pairs fully delivered (lane 1 handshaken), wraps at 2^32.

Behaviour:
- Reset: state=IDLE, hold[0..1]=0, q_pop=0, out_valid=0, out_data=0, out_last=0, pair_count=0. Reset takes priority over flush and all other inputs.
- States:
  - IDLE: nothing held.
  - WAIT: pop accepted last cycle; q_out valid this cycle.
  - SEND0: presenting hold[0].
  - SEND1: presenting hold[1].
- pop_ok = !q_empty && !q_push && !flush.
- q_pop = (IDLE && pop_ok) || (SEND1 && out_ready && pop_ok).
  - Because q_push is excluded, q_pop is never asserted in a cycle where the queue would ignore it; every asserted pop is accepted.
- Transitions (no flush):
  - IDLE: q_pop -> WAIT; else stay.
  - WAIT: capture hold[0]<=q_out[0], hold[1]<=q_out[1]; -> SEND0 unconditionally.
  - SEND0: out_valid=1, out_data=hold[0], out_last=0; out_ready -> SEND1; else hold (out_data stable).
  - SEND1: out_valid=1, out_data=hold[1], out_last=1; on out_ready: pair_count+=1, then q_pop -> WAIT, else -> IDLE. Without out_ready: hold.
- In IDLE and WAIT: out_valid=0, out_last=0, out_data=0.
- Latency: first q_pop in cycle t -> capture at end of t+1 -> out_valid in t+2 (lane 0). Back-to-back pairs with a ready consumer: one entry per cycle in SEND states, one bubble (WAIT) between pairs; 2 entries per 3 cycles.
- Flush:
  - Any state -> IDLE next cycle; hold regs are not cleared.
  - out_valid still follows the current state in the flush cycle, but a handshake in that cycle does not increment pair_count.
  - Flush in WAIT discards the popped pair; the queue tail has already advanced, which is intended.
  - q_pop is forced 0 during flush.
- q_out is sampled only in WAIT; changes on q_out in other states are ignored.
- q_empty rising between pop and capture has no effect; data is captured regardless.
- pair_count wraps from 32'hFFFF_FFFF to 0.

Test Plan:
- Reset then q_empty=1 for 5 cycles -> q_pop=0, out_valid=0, state IDLE, pair_count=0.
- Queue holds {0xA0, 0xA1}, out_ready=1 -> q_pop in cycle 1; out_data=0xA0 (out_last=0) in cycle 3; out_data=0xA1 (out_last=1) in cycle 4; pair_count=1 afterwards.
- Three pairs queued, out_ready=1 continuously -> q_pop in SEND1 of each pair; 6 entries in order with a one-cycle gap between pairs; pair_count=3.
- q_empty=0 with q_push=1 for 3 cycles -> q_pop stays 0; pop issues the first cycle q_push=0.
- out_ready=0 for 4 cycles in SEND0 -> out_data stable at lane 0; no pop; lane 1 follows once ready rises.
- Flush in WAIT -> next cycle IDLE, out_valid=0, popped pair never appears, pair_count unchanged; flush with out_ready in SEND1 -> no count increment, no pop.
